// File: rtl/mfp_ahb_pkg.sv
// Shared AHB-Lite encodings and pipeline-stage records for the mfp AHB masters and slaves.
package mfp_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Address-phase stage: everything needed to drive the bus and to carry into the data phase.
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } addr_stage_t;

  // Data-phase stage: only the low address bits survive, for lane selection.
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [1:0]  size;
    logic [1:0]  addr_lo;
    logic [31:0] wdata;
  } data_stage_t;

endpackage

// File: rtl/mfp_ahb_lite_master_if.sv
// Request/response handshake plus AHB-Lite bus signals of the mfp AHB-Lite master.
interface mfp_ahb_lite_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  // The master modport is the bridge's own view; slave is the view of whatever surrounds it.
  modport master (
    input  req_valid, req_write, req_addr, req_size, req_wdata,
    input  HREADY, HRESP, HRDATA,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output HADDR, HTRANS, HBURST, HSIZE, HWRITE, HWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_wdata,
    output HREADY, HRESP, HRDATA,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  HADDR, HTRANS, HBURST, HSIZE, HWRITE, HWDATA
  );

endinterface

// File: rtl/mfp_ahb_lane_mux.sv
// Byte-lane handling for AHB-Lite masters: write-data replication and read-data extraction.
module mfp_ahb_lane_mux
  import mfp_ahb_pkg::*;
#(
  parameter bit RDATA_ALIGN = 1'b1
) (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  output logic [31:0] rdata
);

  logic [31:0] byte_shifted;
  logic [31:0] half_shifted;

  assign byte_shifted = hrdata >> {addr_lo, 3'b000};
  assign half_shifted = hrdata >> {addr_lo[1], 4'b0000};

  always_comb begin
    hwdata = wdata;
    unique case (size)
      HSIZE_BYTE[1:0]: hwdata = {4{wdata[7:0]}};
      HSIZE_HALF[1:0]: hwdata = {2{wdata[15:0]}};
      default:         hwdata = wdata;
    endcase
  end

  // Size 3 falls through to the word case on both paths.
  always_comb begin
    rdata = hrdata;
    if (RDATA_ALIGN) begin
      unique case (size)
        HSIZE_BYTE[1:0]: rdata = {24'h000000, byte_shifted[7:0]};
        HSIZE_HALF[1:0]: rdata = {16'h0000, half_shifted[15:0]};
        default:         rdata = hrdata;
      endcase
    end
  end

endmodule

// File: rtl/mfp_ahb_lite_master.sv
// Single-initiator AHB-Lite master: valid/ready requests in, one in-order response per transfer.
module mfp_ahb_lite_master
  import mfp_ahb_pkg::*;
#(
  parameter bit RDATA_ALIGN = 1'b1
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  mfp_ahb_lite_master_if.master bus
);

  addr_stage_t a_q;
  data_stage_t d_q;

  logic        rsp_valid_q;
  logic        rsp_error_q;
  logic [31:0] rsp_rdata_q;

  logic        accept;
  logic        complete;
  logic [31:0] lane_hwdata;
  logic [31:0] lane_rdata;

  // An empty address stage may fill even during a wait state (IDLE -> NONSEQ is legal there).
  assign bus.req_ready = !a_q.valid || bus.HREADY;
  assign accept        = bus.req_valid && bus.req_ready;
  assign complete      = d_q.valid && bus.HREADY;

  mfp_ahb_lane_mux #(
    .RDATA_ALIGN(RDATA_ALIGN)
  ) u_lane_mux (
    .size   (d_q.size),
    .addr_lo(d_q.addr_lo),
    .wdata  (d_q.wdata),
    .hwdata (lane_hwdata),
    .hrdata (bus.HRDATA),
    .rdata  (lane_rdata)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      a_q         <= '0;
      d_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (bus.HREADY) begin
        d_q <= '{valid:   a_q.valid,
                 write:   a_q.write,
                 size:    a_q.size,
                 addr_lo: a_q.addr[1:0],
                 wdata:   a_q.wdata};
      end

      if (accept) begin
        a_q <= '{valid: 1'b1,
                 write: bus.req_write,
                 size:  bus.req_size,
                 addr:  bus.req_addr,
                 wdata: bus.req_wdata};
      end else if (bus.HREADY) begin
        a_q.valid <= 1'b0;
      end

      rsp_valid_q <= complete;
      rsp_error_q <= complete && (bus.HRESP == HRESP_ERROR);
      if (complete) begin
        rsp_rdata_q <= (d_q.write || (bus.HRESP == HRESP_ERROR)) ? '0 : lane_rdata;
      end
    end
  end

  assign bus.HTRANS = a_q.valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR  = a_q.addr;
  assign bus.HSIZE  = {1'b0, a_q.size};
  assign bus.HWRITE = a_q.write;
  assign bus.HBURST = HBURST_SINGLE;
  assign bus.HWDATA = lane_hwdata;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Bench for mfp_ahb_lite_master: aligned and raw-read instances share one behavioural AHB slave.
module tb_mfp_ahb_lite_master;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  mfp_ahb_lite_master_if bus_a ();
  mfp_ahb_lite_master_if bus_b ();

  mfp_ahb_lite_master #(.RDATA_ALIGN(1'b1)) dut_al (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus_a)
  );

  mfp_ahb_lite_master #(.RDATA_ALIGN(1'b0)) dut_raw (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus_b)
  );

  assign bus_b.req_valid = bus_a.req_valid;
  assign bus_b.req_write = bus_a.req_write;
  assign bus_b.req_addr  = bus_a.req_addr;
  assign bus_b.req_size  = bus_a.req_size;
  assign bus_b.req_wdata = bus_a.req_wdata;
  assign bus_b.HREADY    = bus_a.HREADY;
  assign bus_b.HRESP     = bus_a.HRESP;
  assign bus_b.HRDATA    = bus_a.HRDATA;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  logic [31:0] err_addr   = 32'hFFFF_FFFF;
  logic [31:0] wait_addr  = 32'hFFFF_FFFF;
  int          wait_n     = 0;
  bit          rand_waits = 1'b0;
  int          exp_lat    = 0;

  // ---------------- behavioural AHB slave (256-byte memory) ----------------
  logic [7:0]  smem [256] = '{default: 8'h00};
  logic        dp_valid = 1'b0;
  logic        dp_write = 1'b0;
  logic        dp_err = 1'b0;
  logic        err_second = 1'b0;
  logic [31:0] dp_addr = '0;
  logic [1:0]  dp_size = '0;
  int          wcnt = 0;
  logic [31:0] sword;

  assign sword = {smem[{dp_addr[7:2], 2'b11}], smem[{dp_addr[7:2], 2'b10}],
                  smem[{dp_addr[7:2], 2'b01}], smem[{dp_addr[7:2], 2'b00}]};
  assign bus_a.HREADY = !dp_valid ? 1'b1 : (dp_err ? err_second : (wcnt == 0));
  assign bus_a.HRESP  = dp_valid && dp_err;
  assign bus_a.HRDATA = (dp_valid && !dp_write) ? sword : 32'hBAD0_CAFE;

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_valid   <= 1'b0;
      err_second <= 1'b0;
      wcnt       <= 0;
    end else begin
      if (dp_valid && !bus_a.HREADY) begin
        if (dp_err) err_second <= 1'b1;
        else        wcnt <= wcnt - 1;
      end
      if (bus_a.HREADY) begin
        if (dp_valid && !dp_err && dp_write) begin
          case (dp_size)
            2'd0: smem[dp_addr[7:0]] <= bus_a.HWDATA[8*dp_addr[1:0] +: 8];
            2'd1: begin
              smem[{dp_addr[7:1], 1'b0}] <= bus_a.HWDATA[16*dp_addr[1] +: 8];
              smem[{dp_addr[7:1], 1'b1}] <= bus_a.HWDATA[16*dp_addr[1] + 8 +: 8];
            end
            default: begin
              smem[{dp_addr[7:2], 2'b00}] <= bus_a.HWDATA[7:0];
              smem[{dp_addr[7:2], 2'b01}] <= bus_a.HWDATA[15:8];
              smem[{dp_addr[7:2], 2'b10}] <= bus_a.HWDATA[23:16];
              smem[{dp_addr[7:2], 2'b11}] <= bus_a.HWDATA[31:24];
            end
          endcase
        end
        dp_valid   <= (bus_a.HTRANS == 2'b10);
        dp_addr    <= bus_a.HADDR;
        dp_write   <= bus_a.HWRITE;
        dp_size    <= bus_a.HSIZE[1:0];
        dp_err     <= (bus_a.HADDR == err_addr);
        err_second <= 1'b0;
        wcnt       <= rand_waits ? int'($urandom_range(0, 2)) :
                      ((bus_a.HADDR == wait_addr) ? wait_n : 0);
      end
    end
  end

  // ---------------- reference model: byte memory plus expected-response queue ----------------
  typedef struct {
    logic        err;
    logic [31:0] rd_al;
    logic [31:0] rd_raw;
    int          acc;
    int          lat;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] mm [256] = '{default: 8'h00};

  function automatic logic [31:0] mword(input logic [31:0] a);
    int b = int'(a[7:0]) & ~3;
    return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] s);
    int i = int'(a[7:0]);
    if (s == 2'd0) return {24'h0, mm[i]};
    if (s == 2'd1) return {16'h0, mm[(i & ~1) + 1], mm[i & ~1]};
    return mword(a);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [1:0] s,
                                      input logic [31:0] d);
    int i = int'(a[7:0]);
    if (s == 2'd0) begin
      mm[i] = d[7:0];
    end else if (s == 2'd1) begin
      mm[i & ~1]       = d[7:0];
      mm[(i & ~1) + 1] = d[15:8];
    end else begin
      for (int k = 0; k < 4; k++) mm[(i & ~3) + k] = d[8*k +: 8];
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns one negedge after the accepting posedge.
  task automatic send(input logic w, input logic [31:0] a, input logic [1:0] s,
                      input logic [31:0] d);
    int   n = 0;
    exp_t e;
    bus_a.req_valid = 1'b1;
    bus_a.req_write = w;
    bus_a.req_addr  = a;
    bus_a.req_size  = s;
    bus_a.req_wdata = d;
    while (!bus_a.req_ready && n < 40) begin
      @(negedge HCLK);
      n++;
    end
    check("req_accept_timeout", {31'b0, n < 40}, 32'd1);
    if (n < 40) begin
      e.err    = (a == err_addr);
      e.acc    = cyc;
      e.lat    = exp_lat;
      e.rd_al  = '0;
      e.rd_raw = '0;
      if (!e.err) begin
        if (w) begin
          model_write(a, s, d);
        end else begin
          e.rd_al  = model_read(a, s);
          e.rd_raw = mword(a);
        end
      end
      expq.push_back(e);
      @(negedge HCLK);
    end
    bus_a.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 60) begin
      @(negedge HCLK);
      n++;
    end
    check("drain_timeout", 32'(expq.size()), 32'd0);
  endtask

  // Response monitor: every pulse must match the head of the expected queue.
  always @(negedge HCLK) begin : mon
    exp_t e;
    if (bus_a.rsp_valid === 1'b1 || bus_b.rsp_valid === 1'b1) begin
      if (expq.size() == 0) begin
        check("spurious_rsp_valid", {31'b0, bus_a.rsp_valid | bus_b.rsp_valid}, 32'd0);
      end else begin
        e = expq.pop_front();
        check("rsp_valid_al", {31'b0, bus_a.rsp_valid}, 32'd1);
        check("rsp_valid_raw", {31'b0, bus_b.rsp_valid}, 32'd1);
        check("rsp_error_al", {31'b0, bus_a.rsp_error}, {31'b0, e.err});
        check("rsp_error_raw", {31'b0, bus_b.rsp_error}, {31'b0, e.err});
        check("rsp_rdata_al", bus_a.rsp_rdata, e.rd_al);
        check("rsp_rdata_raw", bus_b.rsp_rdata, e.rd_raw);
        if (e.lat != 0) check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.req_valid = 1'b0;
    bus_a.req_write = 1'b0;
    bus_a.req_addr  = '0;
    bus_a.req_size  = '0;
    bus_a.req_wdata = '0;

    // Reset state
    repeat (2) @(negedge HCLK);
    check("rst_htrans", {30'b0, bus_a.HTRANS}, 32'd0);
    check("rst_haddr", bus_a.HADDR, 32'd0);
    check("rst_hsize", {29'b0, bus_a.HSIZE}, 32'd0);
    check("rst_hwrite", {31'b0, bus_a.HWRITE}, 32'd0);
    check("rst_hwdata", bus_a.HWDATA, 32'd0);
    check("rst_hburst", {29'b0, bus_a.HBURST}, 32'd0);
    check("rst_req_ready", {31'b0, bus_a.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
    check("rst_rsp_error", {31'b0, bus_a.rsp_error}, 32'd0);
    check("rst_rsp_rdata", bus_b.rsp_rdata, 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Word write then read, zero wait
    exp_lat = 3;
    send(1'b1, 32'h10, 2'd2, 32'hDEAD_BEEF);
    check("t1_htrans_wr", {30'b0, bus_a.HTRANS}, 32'd2);
    check("t1_haddr_wr", bus_a.HADDR, 32'h10);
    check("t1_hwrite_wr", {31'b0, bus_a.HWRITE}, 32'd1);
    check("t1_hsize_wr", {29'b0, bus_a.HSIZE}, 32'd2);
    send(1'b0, 32'h10, 2'd2, 32'h0);
    check("t1_htrans_rd", {30'b0, bus_a.HTRANS}, 32'd2);
    check("t1_hwrite_rd", {31'b0, bus_a.HWRITE}, 32'd0);
    check("t1_hwdata", bus_a.HWDATA, 32'hDEAD_BEEF);
    drain();

    // Byte and half writes: lane replication and aligned/raw readback
    send(1'b1, 32'h13, 2'd0, 32'h0000_00A5);
    check("t2_hsize_byte", {29'b0, bus_a.HSIZE}, 32'd0);
    send(1'b0, 32'h13, 2'd0, 32'h0);
    check("t2_hwdata_byte", bus_a.HWDATA, 32'hA5A5_A5A5);
    drain();
    send(1'b1, 32'h22, 2'd1, 32'h0000_1234);
    check("t2_hsize_half", {29'b0, bus_a.HSIZE}, 32'd1);
    send(1'b0, 32'h22, 2'd1, 32'h0);
    check("t2_hwdata_half", bus_a.HWDATA, 32'h1234_1234);
    drain();

    // Two wait states on a read with a second request pending
    exp_lat   = 0;
    wait_addr = 32'h10;
    wait_n    = 2;
    send(1'b0, 32'h10, 2'd2, 32'h0);
    send(1'b0, 32'h20, 2'd2, 32'h0);
    for (int k = 0; k < 2; k++) begin
      check("t3_wait_hready", {31'b0, bus_a.HREADY}, 32'd0);
      check("t3_wait_htrans", {30'b0, bus_a.HTRANS}, 32'd2);
      check("t3_wait_haddr", bus_a.HADDR, 32'h20);
      check("t3_wait_req_ready", {31'b0, bus_a.req_ready}, 32'd0);
      @(negedge HCLK);
    end
    check("t3_after_req_ready", {31'b0, bus_a.req_ready}, 32'd1);
    drain();
    wait_addr = 32'hFFFF_FFFF;

    // ERROR response on a write, following read still OKAY
    send(1'b1, 32'h44, 2'd2, 32'hCAFE_F00D);
    drain();
    err_addr = 32'h40;
    send(1'b1, 32'h40, 2'd2, 32'h1111_2222);
    send(1'b0, 32'h44, 2'd2, 32'h0);
    check("t4_err_first_hresp", {31'b0, bus_a.HRESP}, 32'd1);
    check("t4_err_first_hready", {31'b0, bus_a.HREADY}, 32'd0);
    check("t4_err_req_ready", {31'b0, bus_a.req_ready}, 32'd0);
    check("t4_err_haddr_held", bus_a.HADDR, 32'h44);
    drain();
    err_addr = 32'h44;
    send(1'b0, 32'h44, 2'd2, 32'h0);
    drain();
    err_addr = 32'hFFFF_FFFF;
    send(1'b0, 32'h40, 2'd2, 32'h0);
    drain();

    // Eight back-to-back word reads
    exp_lat = 3;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 32'h10 + 32'(4 * i), 2'd2, 32'h0);
      check("t5_htrans", {30'b0, bus_a.HTRANS}, 32'd2);
      check("t5_req_ready", {31'b0, bus_a.req_ready}, 32'd1);
    end
    drain();

    // Reset while a read sits in its data phase
    exp_lat   = 0;
    wait_addr = 32'h30;
    wait_n    = 3;
    send(1'b0, 32'h30, 2'd2, 32'h0);
    @(negedge HCLK);
    check("t6_pre_rst_hready", {31'b0, bus_a.HREADY}, 32'd0);
    HRESETn = 1'b0;
    expq.delete();
    @(negedge HCLK);
    HRESETn = 1'b1;
    check("t6_htrans", {30'b0, bus_a.HTRANS}, 32'd0);
    check("t6_req_ready", {31'b0, bus_a.req_ready}, 32'd1);
    check("t6_rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
    repeat (5) @(negedge HCLK);
    check("t6_rsp_valid_later", {31'b0, bus_a.rsp_valid}, 32'd0);
    wait_addr = 32'hFFFF_FFFF;
    exp_lat   = 3;
    send(1'b0, 32'h10, 2'd2, 32'h0);
    drain();

    // Randomized traffic with random wait states and an error address
    exp_lat    = 0;
    rand_waits = 1'b1;
    err_addr   = 32'h40;
    for (int i = 0; i < 80; i++) begin
      send(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
           $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge HCLK);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_lite_master.md
Name: mfp_ahb_lite_master

Overview:
- Single-initiator AHB-Lite master bridging a simple valid/ready request port onto the AHB-Lite bus.
- Counterpart of the team's AHB-Lite memory and peripheral slaves; used by DMA-style engines and test harnesses to drive those slaves.
- Issues SINGLE transfers only.
- Two-stage pipelining: the address phase of transfer N+1 overlaps the data phase of transfer N. One response is returned per request, in order.

Parameters:
- RDATA_ALIGN, 1: 1 = read data is shifted down to bit 0 by byte lane and zero-extended; 0 = raw HRDATA is returned.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset; synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted on the HCLK edge where req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address, forwarded unchanged; no alignment check
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- req_wdata  in  32  right-justified write data
- rsp_valid  out  1  one-cycle pulse per completed transfer
- rsp_rdata  out  32  read data; 0 for writes
- rsp_error  out  1  transfer ended with HRESP = ERROR
- HADDR  out  32  address-phase address
- HTRANS  out  2  2'b00 IDLE, 2'b10 NONSEQ only
- HBURST  out  3  constant 3'b000 (SINGLE)
- HSIZE  out  3  {1'b0, size}
- HWRITE  out  1  address-phase direction
- HWDATA  out  32  data-phase write data
- HREADY  in  1  transfer-complete / bus-ready
- HRESP  in  1  0 OKAY, 1 ERROR
- HRDATA  in  32  read data

Behaviour:
- Reset:
  - Synchronous; when HRESETn = 0 at a HCLK edge, all state clears.
  - Address stage (A) and data stage (D) become empty; rsp_valid = 0.
  - HTRANS = IDLE; HADDR, HSIZE, HWRITE, HWDATA, rsp_rdata = 0; rsp_error = 0.
  - Reset in mid-transfer drops all in-flight transfers with no response.
- Stage A register: valid, addr, write, size, wdata. It drives HTRANS = A.valid ? NONSEQ : IDLE, plus HADDR, HSIZE and HWRITE.
- Stage D register: valid, write, size, addr[1:0], wdata. It drives HWDATA.
- Write lane replication on HWDATA:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- req_ready = !A.valid || HREADY. It is combinational, and is not gated by req_valid.
- At each HCLK edge with HREADY = 1:
  - D <- A.
  - A <- the accepted request if there is one; otherwise A becomes empty.
- At each HCLK edge with HREADY = 0:
  - D holds.
  - A holds if it is valid.
  - If A is empty, A may load an accepted request. This gives the legal IDLE -> NONSEQ change during a wait state.
  - Once A is NONSEQ, its address-phase signals are stable until HREADY = 1.
- Completion: a transfer completes on an edge where D.valid && HREADY. On the next cycle:
  - rsp_valid = 1.
  - rsp_error = HRESP.
  - rsp_rdata: for reads, (RDATA_ALIGN ? lane-extract HRDATA by D.addr[1:0] and D.size, zero-extended : HRDATA). For writes and for errors, 0.
- Error handling (two-cycle ERROR response):
  - The first cycle (HRESP = 1, HREADY = 0) is an ordinary wait.
  - The second cycle completes the transfer with rsp_error = 1.
  - A pending transfer in A is not cancelled; it proceeds normally.
- Throughput and latency:
  - With zero wait states: one transfer per cycle.
  - Request-accept to rsp_valid: 3 cycles.
- No backpressure on the response side; the consumer must always accept rsp_valid.
- rsp_valid does not fire for empty D slots.

Decomposition:
- Shared package mfp_ahb_pkg holds:
  - HTRANS_IDLE / HTRANS_NONSEQ
  - HBURST_SINGLE
  - HSIZE_BYTE / HALF / WORD
  - HRESP_OKAY / HRESP_ERROR
- Natural sub-module: mfp_ahb_lane_mux, the combinational write replication and read extraction, reusable by other masters.
- The FSM and pipeline registers stay in the top module.

Test Plan:
- Word write then read, zero-wait memory slave. Write addr 0x10 data 0xDEADBEEF, then read 0x10 -> HTRANS NONSEQ on 2 consecutive cycles. Read response rdata = 0xDEADBEEF, rsp_error = 0; accept-to-rsp = 3 cycles.
- Byte write to 0x13 with wdata 0x000000A5 -> HSIZE = 0 and HWDATA = 0xA5A5A5A5. Read 0x13 byte -> rsp_rdata = 0x000000A5 with RDATA_ALIGN = 1; 0xA5xxxxxx raw with RDATA_ALIGN = 0.
- Slave inserts 2 wait states on a read while a second request is pending:
  - HADDR/HTRANS of the second transfer are held stable across both waits.
  - req_ready = 0 during the waits.
  - Responses arrive in order.
- ERROR response on a write to 0x40 (HRESP = 1 for 2 cycles, HREADY = 0 then 1) -> rsp_error = 1. The following read to 0x44 still completes with OKAY.
- 8 back-to-back word reads, req_valid held high, zero wait -> req_ready stays 1, HTRANS = NONSEQ for 8 cycles, 8 rsp_valid pulses on consecutive cycles.
- HRESETn = 0 for one cycle while D holds a waiting read -> next cycle HTRANS = IDLE, no rsp_valid for the dropped transfer, req_ready = 1.
